// File: rtl/replay_buffer_cfg_pkg.sv
// Shared sizing helpers and default-width types for the runtime-configurable replay buffer.
package replay_pkg;

   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_MAX_LEN = 16;
   localparam int DEF_MAX_REP = 8;
   localparam int DEF_LW      = clog2_min1(DEF_MAX_LEN);
   localparam int DEF_RW      = clog2_min1(DEF_MAX_REP);

   typedef logic [DEF_LW:0]   ptr_t;
   typedef logic [DEF_LW-1:0] len_t;
   typedef logic [DEF_RW-1:0] rep_t;

endpackage

// File: rtl/replay_buffer_cfg_seq_counter.sv
// Counter with a runtime terminal count: wraps to zero on the increment that sees cnt==tc.
module seq_counter
   import replay_pkg::*;
#(
   parameter int N_W = 4
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           inc,
   input  logic [N_W-1:0] tc,
   output logic [N_W-1:0] cnt,
   output logic           last,
   output logic           wrap
);

   assign last = (cnt == tc);
   assign wrap = inc && last;

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= last ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/replay_buffer_cfg.sv
// Stores a LEN-item sequence and replays it REP times; LEN/REP are loaded per job via a config handshake.
module replay_buffer_cfg
   import replay_pkg::*;
#(
   parameter  int MAX_LEN = 16,
   parameter  int MAX_REP = 8,
   parameter  int W       = 8,
   localparam int LW      = clog2_min1(MAX_LEN),
   localparam int RW      = clog2_min1(MAX_REP)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [LW-1:0] cfg_len,
   input  logic [RW-1:0] cfg_rep,
   input  logic          cfg_vld,
   output logic          cfg_rdy,
   input  logic [W-1:0]  idat,
   input  logic          ivld,
   output logic          irdy,
   output logic [W-1:0]  odat,
   output logic          ovld,
   input  logic          ordy,
   output logic          olast,
   output logic          ofin
);

   localparam int          DEPTH      = 2**LW;
   localparam logic [LW:0] DEPTH_P    = (LW+1)'(DEPTH);
   localparam logic [LW:0] LEN_MAX_M1 = (LW+1)'(MAX_LEN-1);
   localparam logic [RW:0] REP_MAX_M1 = (RW+1)'(MAX_REP-1);

   logic [W-1:0]  mem [DEPTH];
   logic [LW:0]   wp, rp, fp, occ;
   logic [LW-1:0] len_r, item_cnt;
   logic [RW-1:0] rep_r, rep_cnt;
   logic          item_last, item_wrap, rep_last, rep_wrap;
   logic          wr, cfg_acc, rd, vld, shift;

   assign occ     = wp - fp;
   assign irdy    = (occ != DEPTH_P);
   assign wr      = ivld && irdy;
   assign cfg_rdy = (wp == fp) && (item_cnt == '0) && (rep_cnt == '0);
   assign cfg_acc = cfg_vld && cfg_rdy;
   assign rd      = !ovld || ordy;
   assign vld     = (rp != wp);
   assign shift   = rd && vld;

   seq_counter #(.N_W(LW)) u_item_cnt (
      .clk(clk), .clr(rst), .inc(shift), .tc(len_r),
      .cnt(item_cnt), .last(item_last), .wrap(item_wrap)
   );

   seq_counter #(.N_W(RW)) u_rep_cnt (
      .clk(clk), .clr(rst), .inc(item_wrap), .tc(rep_r),
      .cnt(rep_cnt), .last(rep_last), .wrap(rep_wrap)
   );

   // Write side / pointer control: entries are freed only while the final repetition drains
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         fp    <= '0;
         len_r <= LW'(MAX_LEN-1);
         rep_r <= '0;
      end else begin
         if (cfg_acc) begin
            len_r <= cfg_len;
            rep_r <= cfg_rep;
         end
         if (wr)
            wp <= wp + 1'b1;
         if (shift) begin
            rp <= (item_last && !rep_last) ? rp - {1'b0, len_r} : rp + 1'b1;
            if (rep_last)
               fp <= fp + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wp[LW-1:0]] <= idat;
   end

   // Read stage: fully registered output, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         ovld  <= 1'b0;
         olast <= 1'b0;
         ofin  <= 1'b0;
      end else if (rd) begin
         ovld  <= vld;
         olast <= item_wrap;
         ofin  <= rep_wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (rd)
         odat <= mem[rp[LW-1:0]];
   end

   cfg_len_legal: assert property (@(posedge clk) disable iff (rst)
      cfg_acc |-> ({1'b0, cfg_len} <= LEN_MAX_M1));
   cfg_rep_legal: assert property (@(posedge clk) disable iff (rst)
      cfg_acc |-> ({1'b0, cfg_rep} <= REP_MAX_M1));

endmodule

// File: tb/tb_replay_buffer_cfg.sv
// Scoreboard bench for replay_buffer_cfg: directed jobs push expected items, a monitor pops on each transfer.
module tb_replay_buffer_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cfg_len;
   logic [2:0] cfg_rep;
   logic       cfg_vld;
   logic       cfg_rdy;
   logic [7:0] idat;
   logic       ivld;
   logic       irdy;
   logic [7:0] odat;
   logic       ovld;
   logic       ordy;
   logic       olast;
   logic       ofin;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [9:0] sbq[$];
   logic       mon_en    = 1'b1;
   logic       rand_mode = 1'b0;
   logic       ordy_fix  = 1'b1;

   replay_buffer_cfg #(.MAX_LEN(16), .MAX_REP(8), .W(8)) dut (
      .clk(clk), .rst(rst),
      .cfg_len(cfg_len), .cfg_rep(cfg_rep), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
      .idat(idat), .ivld(ivld), .irdy(irdy),
      .odat(odat), .ovld(ovld), .ordy(ordy), .olast(olast), .ofin(ofin)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic exp_item(input logic [7:0] d, input logic l, input logic f);
      sbq.push_back({d, l, f});
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      idat = d;
      ivld = 1'b1;
      @(negedge clk);
      while (!irdy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!irdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL push_timeout: irdy stuck at 0 for item 0x%0h", d);
      end
      @(posedge clk);
      #1;
      ivld = 1'b0;
   endtask

   task automatic config_job(input logic [3:0] l, input logic [2:0] r);
      int t = 0;
      cfg_len = l;
      cfg_rep = r;
      cfg_vld = 1'b1;
      @(negedge clk);
      while (!cfg_rdy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!cfg_rdy) begin
         n_cmp++;
         n_err++;
         $display("FAIL cfg_timeout: cfg_rdy stuck at 0");
      end
      @(posedge clk);
      #1;
      cfg_vld = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((sbq.size() != 0 || ovld) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_drained"}, sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // ordy driver: fixed level or ~30% random ready
   initial begin
      ordy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ordy = rand_mode ? ($urandom_range(0, 99) < 30) : ordy_fix;
      end
   end

   // Monitor: stability under backpressure and scoreboard compare on each transfer
   initial begin
      logic       held;
      logic [9:0] hv;
      logic [9:0] e;
      held = 1'b0;
      hv   = '0;
      forever begin
         @(negedge clk);
         if (!rst && mon_en) begin
            if (held) begin
               chk("hold_ovld", ovld, 1);
               chk("hold_data", {odat, olast, ofin}, hv);
            end
            if (ovld && ordy) begin
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: got {dat,last,fin}=0x%0h, expected none", {odat, olast, ofin});
               end else begin
                  e = sbq.pop_front();
                  chk("out_item", {odat, olast, ofin}, e);
               end
            end
            held = ovld && !ordy;
            hv   = {odat, olast, ofin};
         end else
            held = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, 0 of 1 expected completions");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      cfg_len = '0;
      cfg_rep = '0;
      cfg_vld = 1'b0;
      idat    = '0;
      ivld    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ovld", ovld, 0);
      chk("rst_olast", olast, 0);
      chk("rst_ofin", ofin, 0);
      chk("rst_cfg_rdy", cfg_rdy, 1);
      chk("rst_irdy", irdy, 1);
      @(posedge clk);
      #1;

      // 1: default LEN16 REP1
      for (int i = 0; i < 16; i++) exp_item(8'(i), i == 15, i == 15);
      for (int i = 0; i < 16; i++) push(8'(i));
      drain("t1");

      // 2: LEN4 REP3
      config_job(4'd3, 3'd2);
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++) exp_item(8'hA + 8'(i), i == 3, i == 3 && r == 2);
      for (int i = 0; i < 4; i++) push(8'hA + 8'(i));
      drain("t2");

      // 3: LEN1 REP4
      config_job(4'd0, 3'd3);
      exp_item(8'd7, 1, 0); exp_item(8'd7, 1, 0); exp_item(8'd7, 1, 0); exp_item(8'd7, 1, 1);
      exp_item(8'd9, 1, 0); exp_item(8'd9, 1, 0); exp_item(8'd9, 1, 0); exp_item(8'd9, 1, 1);
      push(8'd7);
      push(8'd9);
      drain("t3");

      // 4: LEN16 REP2, fill to full with consumer stalled, then random backpressure
      config_job(4'd15, 3'd1);
      for (int s = 0; s < 2; s++)
         for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++)
               exp_item(8'h20 + 8'(s * 32 + i), i == 15, i == 15 && r == 1);
      ordy_fix = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
      @(negedge clk);
      chk("t4_irdy_full", irdy, 0);
      chk("t4_cfg_rdy_busy", cfg_rdy, 0);
      @(posedge clk);
      #1;
      rand_mode = 1'b1;
      for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
      drain("t4");
      rand_mode = 1'b0;
      ordy_fix  = 1'b1;
      @(posedge clk);
      #1;

      // 5: config offered during replay must wait for the job to finish
      config_job(4'd3, 3'd1);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) exp_item(8'h61 + 8'(i), i == 3, i == 3 && r == 1);
      for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
      @(negedge clk);
      chk("t5_cfg_rdy_replay", cfg_rdy, 0);
      exp_item(8'h51, 0, 0);
      exp_item(8'h52, 1, 1);
      @(posedge clk);
      #1;
      config_job(4'd1, 3'd0);
      push(8'h51);
      push(8'h52);
      drain("t5");

      // 6: reset in the middle of a repetition, then a fresh job
      mon_en = 1'b0;
      config_job(4'd3, 3'd1);
      for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ovld_after_rst", ovld, 0);
      chk("t6_cfg_rdy_after_rst", cfg_rdy, 1);
      chk("t6_irdy_after_rst", irdy, 1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      config_job(4'd3, 3'd1);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++) exp_item(8'h81 + 8'(i), i == 3, i == 3 && r == 1);
      for (int i = 0; i < 4; i++) push(8'h81 + 8'(i));
      drain("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
